// File: rtl/axi4_lite_initiator_pkg.sv
// Shared types and constants for the AXI4-lite initiator slice:
// FSM state encoding and the AXI protection encodings used on AR/AW.
package axi4_lite_initiator_pkg;

  // One outstanding transaction; the state tells which channel is open.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR   = 3'd3,
    ST_WR_B = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [2:0] PROT_INSN = 3'b100;
  localparam logic [2:0] PROT_DATA = 3'b000;

  // Instruction fetches are tagged through the instruction bit of xPROT.
  function automatic logic [2:0] prot_for(input logic instr);
    return instr ? PROT_INSN : PROT_DATA;
  endfunction

endpackage

// File: rtl/axi4_lite_initiator_if.sv
// Bundle of the core-side native memory port and the five AXI4-lite
// channels. The master modport is the initiator's view of the bus.
interface axi4_lite_initiator_if;

  // Native memory interface (core side)
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // AXI4-lite channels (bus side)
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  modport master (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_awready,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_wready,
    input  mem_axi_bvalid,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_arready,
    input  mem_axi_rvalid, mem_axi_rdata,
    output mem_axi_rready
  );

  modport slave (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_awready,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_wready,
    output mem_axi_bvalid,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_arready,
    output mem_axi_rvalid, mem_axi_rdata,
    input  mem_axi_rready
  );

endinterface

// File: rtl/axi4_lite_wdog.sv
// Transaction watchdog: saturating cycle counter that runs while a
// transaction is open and a sticky flag that sets when it reaches the
// limit. A limit of zero disables both. The flag only clears on reset.
module axi4_lite_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic active_i,
  output logic timeout_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] ONE   = TIMEOUT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] ZERO  = {TIMEOUT_WIDTH{1'b0}};

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;

  // Next count: clear when idle, count up to the limit and hold there.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (TIMEOUT_CYCLES == 0) begin
      cnt_d     = ZERO;
      timeout_d = 1'b0;
    end else if (!active_i) begin
      cnt_d     = ZERO;
      timeout_d = timeout_q;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + ONE;
      if (cnt_q + ONE == LIMIT) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      cnt_d     = cnt_q;
      timeout_d = 1'b1;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= ZERO;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/axi4_lite_initiator.sv
// AXI4-lite initiator: turns one native valid/ready request at a time into
// AR/R or AW/W/B traffic. Every bus output comes straight from a register;
// request fields are latched when leaving IDLE and held until handshake.
module axi4_lite_initiator
  import axi4_lite_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  axi4_lite_initiator_if.master bus,
  output logic                  busy,
  output logic                  timeout
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  prot_q;
  logic        arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
  logic        aw_done_q, w_done_q;
  logic        mem_ready_q;
  logic [31:0] mem_rdata_q;
  logic        busy_q;

  logic ar_fire_s, r_fire_s, aw_fire_s, w_fire_s, b_fire_s;
  logic aw_ok_s, w_ok_s;
  logic wdog_active_s;

  assign ar_fire_s = arvalid_q && bus.mem_axi_arready;
  assign r_fire_s  = rready_q  && bus.mem_axi_rvalid;
  assign aw_fire_s = awvalid_q && bus.mem_axi_awready;
  assign w_fire_s  = wvalid_q  && bus.mem_axi_wready;
  assign b_fire_s  = bready_q  && bus.mem_axi_bvalid;

  // A write side counts as done from the cycle its handshake is sampled.
  assign aw_ok_s = aw_done_q || aw_fire_s;
  assign w_ok_s  = w_done_q  || w_fire_s;

  // The watchdog only runs while a bus channel is actually open.
  assign wdog_active_s = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // Transaction FSM with all bus-facing outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      wstrb_q     <= 4'b0000;
      prot_q      <= 3'b000;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_ready_q <= 1'b0;
          if (bus.mem_valid) begin
            addr_q <= bus.mem_addr;
            prot_q <= prot_for(bus.mem_instr);
            busy_q <= 1'b1;
            if (bus.mem_wstrb == 4'b0000) begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_A;
            end else begin
              wdata_q   <= bus.mem_wdata;
              wstrb_q   <= bus.mem_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_WR;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_RD_A: begin
          if (ar_fire_s) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_D;
          end
        end
        ST_RD_D: begin
          if (r_fire_s) begin
            mem_rdata_q <= bus.mem_axi_rdata;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_WR: begin
          if (aw_fire_s) begin
            awvalid_q <= 1'b0;
          end
          if (w_fire_s) begin
            wvalid_q <= 1'b0;
          end
          aw_done_q <= aw_ok_s;
          w_done_q  <= w_ok_s;
          if (aw_ok_s && w_ok_s) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (b_fire_s) begin
            bready_q    <= 1'b0;
            mem_ready_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // mem_valid is deliberately ignored here; the core is still
          // seeing mem_ready and may not have retired its request yet.
          mem_ready_q <= 1'b0;
          aw_done_q   <= 1'b0;
          w_done_q    <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          arvalid_q   <= 1'b0;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          rready_q    <= 1'b0;
          bready_q    <= 1'b0;
          aw_done_q   <= 1'b0;
          w_done_q    <= 1'b0;
          mem_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  axi4_lite_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_wdog (
    .clk      (clk),
    .resetn   (resetn),
    .active_i (wdog_active_s),
    .timeout_o(timeout)
  );

  assign bus.mem_ready       = mem_ready_q;
  assign bus.mem_rdata       = mem_rdata_q;
  assign bus.mem_axi_awvalid = awvalid_q;
  assign bus.mem_axi_awaddr  = addr_q;
  assign bus.mem_axi_awprot  = PROT_DATA;
  assign bus.mem_axi_wvalid  = wvalid_q;
  assign bus.mem_axi_wdata   = wdata_q;
  assign bus.mem_axi_wstrb   = wstrb_q;
  assign bus.mem_axi_bready  = bready_q;
  assign bus.mem_axi_arvalid = arvalid_q;
  assign bus.mem_axi_araddr  = addr_q;
  assign bus.mem_axi_arprot  = prot_q;
  assign bus.mem_axi_rready  = rready_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// Self-checking bench for axi4_lite_initiator: a behavioural AXI-lite
// responder with programmable per-channel delays, a reference memory and
// latency expectations derived from channel delays.
module tb_axi4_lite_initiator;

  localparam int TO_CYCLES = 8;

  logic clk = 1'b0;
  logic resetn;
  logic busy, timeout;
  int   checks, failures;

  axi4_lite_initiator_if bus();

  axi4_lite_initiator #(.TIMEOUT_CYCLES(TO_CYCLES), .TIMEOUT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // ---------------- responder configuration and state ----------------
  int ar_dly, aw_dly, w_dly, r_dly, b_dly;
  logic [31:0] rsp_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        rsp_init_q = 1'b0;
  int ar_wait, aw_wait, w_wait, r_cnt, b_cnt;
  logic aw_got, w_got, r_pend, b_pend, tests_passed;
  logic [31:0] aw_addr_l, w_data_l, r_data_l;
  logic [3:0]  w_strb_l;
  int ar_hs, aw_hs, w_hs;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [2:0]  last_arprot, last_awprot;
  logic [3:0]  last_wstrb;

  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'hCAFE_BABE;
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  logic ar_fire_s, aw_fire_s, w_fire_s, aw_have_s, w_have_s;
  logic [31:0] cm_addr_s, cm_data_s, rd_word_s;
  logic [3:0]  cm_strb_s;

  assign bus.mem_axi_arready = (ar_wait >= ar_dly);
  assign bus.mem_axi_awready = (aw_wait >= aw_dly);
  assign bus.mem_axi_wready  = (w_wait >= w_dly);
  assign ar_fire_s = bus.mem_axi_arvalid && bus.mem_axi_arready;
  assign aw_fire_s = bus.mem_axi_awvalid && bus.mem_axi_awready;
  assign w_fire_s  = bus.mem_axi_wvalid && bus.mem_axi_wready;
  assign aw_have_s = aw_got || aw_fire_s;
  assign w_have_s  = w_got || w_fire_s;
  assign cm_addr_s = aw_fire_s ? bus.mem_axi_awaddr : aw_addr_l;
  assign cm_data_s = w_fire_s ? bus.mem_axi_wdata : w_data_l;
  assign cm_strb_s = w_fire_s ? bus.mem_axi_wstrb : w_strb_l;
  assign rd_word_s = rsp_mem[bus.mem_axi_araddr[9:2]];

  // Behavioural AXI-lite responder: memory below 0x1000_0000, console at
  // 0x1000_0000 and a pass flag at 0x2000_0000.
  always @(posedge clk) begin
    if (!resetn) begin
      if (!rsp_init_q) begin
        for (int i = 0; i < 256; i++) rsp_mem[i] <= init_word(i);
        rsp_init_q <= 1'b1; tests_passed <= 1'b0;
        ar_hs <= 0; aw_hs <= 0; w_hs <= 0;
      end
      ar_wait <= 0; aw_wait <= 0; w_wait <= 0; r_cnt <= 0; b_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; b_pend <= 1'b0;
      bus.mem_axi_rvalid <= 1'b0; bus.mem_axi_bvalid <= 1'b0; bus.mem_axi_rdata <= 32'h0;
    end else begin
      if (ar_fire_s) begin
        ar_wait <= 0; ar_hs <= ar_hs + 1;
        last_araddr <= bus.mem_axi_araddr; last_arprot <= bus.mem_axi_arprot;
        if (r_dly == 0) begin
          bus.mem_axi_rvalid <= 1'b1; bus.mem_axi_rdata <= rd_word_s;
        end else begin
          r_pend <= 1'b1; r_cnt <= 1; r_data_l <= rd_word_s;
        end
      end else if (bus.mem_axi_arvalid) ar_wait <= ar_wait + 1;
      if (r_pend) begin
        if (r_cnt >= r_dly) begin
          bus.mem_axi_rvalid <= 1'b1; bus.mem_axi_rdata <= r_data_l; r_pend <= 1'b0;
        end else r_cnt <= r_cnt + 1;
      end
      if (bus.mem_axi_rvalid && bus.mem_axi_rready) bus.mem_axi_rvalid <= 1'b0;

      if (aw_fire_s) begin
        aw_wait <= 0; aw_hs <= aw_hs + 1; aw_addr_l <= bus.mem_axi_awaddr;
        last_awaddr <= bus.mem_axi_awaddr; last_awprot <= bus.mem_axi_awprot;
      end else if (bus.mem_axi_awvalid) aw_wait <= aw_wait + 1;
      if (w_fire_s) begin
        w_wait <= 0; w_hs <= w_hs + 1; w_data_l <= bus.mem_axi_wdata; w_strb_l <= bus.mem_axi_wstrb;
        last_wdata <= bus.mem_axi_wdata; last_wstrb <= bus.mem_axi_wstrb;
      end else if (bus.mem_axi_wvalid) w_wait <= w_wait + 1;
      if (aw_have_s && w_have_s) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        if (cm_addr_s == 32'h1000_0000) $display("responder console: %c", cm_data_s[7:0]);
        else if (cm_addr_s == 32'h2000_0000) begin
          if (cm_data_s == 32'd123456789) tests_passed <= 1'b1;
        end else if (cm_addr_s[31:28] == 4'h0)
          rsp_mem[cm_addr_s[9:2]] <= merge_bytes(rsp_mem[cm_addr_s[9:2]], cm_data_s, cm_strb_s);
        if (b_dly == 0) bus.mem_axi_bvalid <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= 1; end
      end else begin
        aw_got <= aw_have_s; w_got <= w_have_s;
      end
      if (b_pend) begin
        if (b_cnt >= b_dly) begin bus.mem_axi_bvalid <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt + 1;
      end
      if (bus.mem_axi_bvalid && bus.mem_axi_bready) bus.mem_axi_bvalid <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
    bus.mem_instr = instr; bus.mem_addr = addr; bus.mem_wdata = wdata; bus.mem_wstrb = strb;
    bus.mem_valid = 1'b1;
  endtask

  // Count rising edges until mem_ready is seen, bounded by budget.
  task automatic wait_ready(input int budget, output int lat, output logic seen);
    lat = 0; seen = 1'b0;
    while (!seen && lat < budget) begin
      @(posedge clk); lat++; @(negedge clk);
      if (bus.mem_ready) seen = 1'b1;
    end
  endtask

  task automatic finish_req(input string tag);
    bus.mem_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.mem_ready), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // One complete transaction checked against the reference model.
  task automatic do_txn(input string tag, input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int exp_lat);
    int ar0, aw0, w0, lat; logic seen;
    ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
    drive_req(instr, addr, wdata, strb);
    wait_ready(exp_lat + 6, lat, seen);
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (strb == 4'b0000) begin
      chk({tag, "_rdata"}, bus.mem_rdata, ref_mem[addr[9:2]]);
      chk({tag, "_araddr"}, last_araddr, addr);
      chk({tag, "_arprot"}, 32'(last_arprot), 32'({instr, 2'b00}));
      chk({tag, "_ar_cnt"}, 32'(ar_hs - ar0), 32'd1);
      chk({tag, "_aw_cnt"}, 32'(aw_hs - aw0), 32'd0);
    end else begin
      if (addr[31:28] == 4'h0) ref_mem[addr[9:2]] = merge_bytes(ref_mem[addr[9:2]], wdata, strb);
      chk({tag, "_awaddr"}, last_awaddr, addr);
      chk({tag, "_wdata"}, last_wdata, wdata);
      chk({tag, "_wstrb"}, 32'(last_wstrb), 32'(strb));
      chk({tag, "_awprot"}, 32'(last_awprot), 32'd0);
      chk({tag, "_aw_cnt"}, 32'(aw_hs - aw0), 32'd1);
      chk({tag, "_w_cnt"}, 32'(w_hs - w0), 32'd1);
      chk({tag, "_ar_cnt"}, 32'(ar_hs - ar0), 32'd0);
    end
    finish_req(tag);
  endtask

  task automatic set_dly(input int ar, input int r, input int aw, input int w, input int b);
    ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat, c, hs_c, rdy_c, ar0, aw0;
    logic seen, done;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        ins;
    checks = 0; failures = 0;
    set_dly(0, 0, 0, 0, 0);
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = 32'h0;
    bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_valids", 32'({bus.mem_axi_arvalid, bus.mem_axi_awvalid, bus.mem_axi_wvalid}), 32'd0);
    chk("rst_readies", 32'({bus.mem_axi_rready, bus.mem_axi_bready, bus.mem_ready}), 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_araddr", bus.mem_axi_araddr, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Zero-wait instruction read.
    do_txn("rd0", 1'b1, 32'h0000_0100, 32'h0, 4'b0000, 3);
    chk("rd0_cafe", ref_mem[64], 32'hCAFE_BABE);

    // Write with wready four cycles behind awready.
    set_dly(0, 0, 0, 4, 0);
    drive_req(1'b0, 32'h1000_0000, 32'h0000_0041, 4'b0001);
    @(posedge clk); @(negedge clk);
    chk("wd_aw_w_up", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid}), 32'd3);
    @(posedge clk); @(negedge clk);
    chk("wd_aw_drop", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid}), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      chk("wd_bready_early", 32'(bus.mem_axi_bready), 32'd0);
      chk("wd_w_held", 32'(bus.mem_axi_wvalid), 32'd1);
    end
    @(posedge clk); @(negedge clk);
    chk("wd_bready", 32'({bus.mem_axi_wvalid, bus.mem_axi_bready}), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("wd_ready", 32'(bus.mem_ready), 32'd1);
    chk("wd_wdata", last_wdata, 32'h0000_0041);
    finish_req("wd");

    // aw and w in the same cycle, bvalid three cycles late.
    set_dly(0, 0, 0, 0, 3);
    drive_req(1'b0, 32'h2000_0000, 32'd123456789, 4'b1111);
    hs_c = -1; rdy_c = -1; c = 0;
    while (rdy_c < 0 && c < 15) begin
      @(posedge clk); c++; @(negedge clk);
      if (c == 2) chk("ws_both_drop", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid}), 32'd0);
      if (bus.mem_axi_bvalid && bus.mem_axi_bready && hs_c < 0) hs_c = c;
      if (bus.mem_ready) rdy_c = c;
    end
    chk("ws_b_to_ready", 32'(rdy_c - hs_c), 32'd1);
    chk("ws_lat", 32'(rdy_c), 32'd6);
    chk("ws_tests_passed", 32'(tests_passed), 32'd1);
    finish_req("ws");

    // Back-to-back read then write with mem_valid held throughout.
    set_dly(0, 0, 0, 0, 0);
    ar0 = ar_hs; aw0 = aw_hs;
    drive_req(1'b0, 32'h0000_0080, 32'h0, 4'b0000);
    wait_ready(10, lat, seen);
    chk("bb_rd_lat", 32'(lat), 32'd3);
    chk("bb_rd_data", bus.mem_rdata, ref_mem[32]);
    drive_req(1'b0, 32'h0000_0084, 32'h1234_5678, 4'b1111);
    @(posedge clk); @(negedge clk);
    chk("bb_gap", 32'({bus.mem_axi_awvalid, busy}), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("bb_aw_start", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid, busy}), 32'd7);
    wait_ready(10, lat, seen);
    chk("bb_wr_lat", 32'(lat), 32'd2);
    ref_mem[33] = 32'h1234_5678;
    finish_req("bb");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bb_ar_once", 32'(ar_hs - ar0), 32'd1);
    chk("bb_aw_once", 32'(aw_hs - aw0), 32'd1);
    do_txn("bb_rb", 1'b0, 32'h0000_0084, 32'h0, 4'b0000, 3);

    // Randomized traffic with short responder delays.
    for (int n = 0; n < 40; n++) begin
      set_dly($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2));
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d = $urandom;
      ins = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        s = 4'($urandom_range(1, 15));
        do_txn("rnd_wr", ins, a, d, s, 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly);
      end else begin
        do_txn("rnd_rd", ins, a, 32'h0, 4'b0000, 3 + ar_dly + r_dly);
      end
    end
    chk("pre_wd_timeout", 32'(timeout), 32'd0);

    // Hung arready: watchdog fires after the limit but the read still ends.
    set_dly(20, 0, 0, 0, 0);
    drive_req(1'b0, 32'h0000_000C, 32'h0, 4'b0000);
    done = 1'b0; c = 0;
    while (!done && c < 40) begin
      @(posedge clk); c++; @(negedge clk);
      if (bus.mem_ready) done = 1'b1;
      else begin
        chk("wd_flag", 32'(timeout), 32'((c - 1) >= TO_CYCLES));
        if (c <= 21) chk("wd_arvalid", 32'(bus.mem_axi_arvalid), 32'd1);
      end
    end
    chk("wd_done", 32'(done), 32'd1);
    chk("wd_lat", 32'(c), 32'd23);
    chk("wd_rdata", bus.mem_rdata, ref_mem[3]);
    finish_req("wdr");
    chk("wd_sticky", 32'(timeout), 32'd1);

    // Reset while waiting in the write-response state.
    set_dly(0, 0, 0, 0, 6);
    drive_req(1'b0, 32'h0000_0020, 32'h0BAD_F00D, 4'b1111);
    ref_mem[8] = 32'h0BAD_F00D;
    seen = 1'b0; c = 0;
    while (!seen && c < 10) begin
      @(posedge clk); c++; @(negedge clk);
      if (bus.mem_axi_bready) seen = 1'b1;
    end
    chk("rs_reach_wrb", 32'(seen), 32'd1);
    bus.mem_valid = 1'b0;
    resetn = 1'b0;
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    chk("rs_valids", 32'({bus.mem_axi_arvalid, bus.mem_axi_awvalid, bus.mem_axi_wvalid}), 32'd0);
    chk("rs_readies", 32'({bus.mem_axi_rready, bus.mem_axi_bready, bus.mem_ready}), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_timeout", 32'(timeout), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rs_still_idle", 32'({busy, bus.mem_axi_bready}), 32'd0);
    set_dly(0, 0, 0, 0, 0);
    do_txn("rs_rd", 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
